// File: rtl/run_detect_pkg.sv
// Shared types, run-mode constants and the qualification helper for run_detect.
package run_detect_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    TRACK = 2'b01,
    FULL  = 2'b10
  } rd_state_t;

  localparam logic [1:0] RD_BOTH  = 2'b00;
  localparam logic [1:0] RD_ONES  = 2'b01;
  localparam logic [1:0] RD_ZEROS = 2'b10;
  localparam logic [1:0] RD_OFF   = 2'b11;

  function automatic logic allow(input logic v, input logic [1:0] mode);
    return (mode == RD_BOTH) | ((mode == RD_ONES) & v) | ((mode == RD_ZEROS) & ~v);
  endfunction

endpackage

// File: rtl/run_detect_ch.sv
// One channel of the run detector: run-tracking FSM, saturating counter, registered outputs.
module run_detect_ch
  import run_detect_pkg::*;
#(
  parameter int unsigned RUN   = 4,
  parameter int unsigned CNT_W = $clog2(RUN + 1)
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       clr,
  input  logic [1:0] mode,
  input  logic       en,
  input  logic       w,
  output logic       q,
  output logic       hit,
  output logic       val
);

  localparam logic [CNT_W-1:0] RunMax = CNT_W'(RUN);

  rd_state_t        st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             val_q, val_d;
  logic             q_q, q_d;
  logic             hit_q, hit_d;

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    val_d = val_q;
    if (clr) begin
      st_d  = IDLE;
      cnt_d = '0;
      val_d = 1'b0;
    end else if (en) begin
      unique case (st_q)
        IDLE: begin
          st_d  = TRACK;
          cnt_d = CNT_W'(1);
          val_d = w;
        end
        TRACK: begin
          if (w == val_q) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == RunMax - CNT_W'(1)) begin
              st_d = FULL;
            end
          end else begin
            cnt_d = CNT_W'(1);
            val_d = w;
          end
        end
        FULL: begin
          // Equal samples keep the saturated count; only a break restarts tracking.
          if (w != val_q) begin
            st_d  = TRACK;
            cnt_d = CNT_W'(1);
            val_d = w;
          end
        end
        default: begin
          st_d  = IDLE;
          cnt_d = '0;
          val_d = 1'b0;
        end
      endcase
    end
    q_d   = (st_d == FULL) & allow(val_d, mode);
    hit_d = q_d & ~q_q;
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      st_q  <= IDLE;
      cnt_q <= '0;
      val_q <= 1'b0;
      q_q   <= 1'b0;
      hit_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      val_q <= val_d;
      q_q   <= q_d;
      hit_q <= hit_d;
    end
  end

  assign q   = q_q;
  assign hit = hit_q;
  assign val = val_q;

endmodule

// File: rtl/run_detect.sv
// Multi-channel run-length detector; one independent run_detect_ch per serial input.
module run_detect
  import run_detect_pkg::*;
#(
  parameter int unsigned CH    = 1,
  parameter int unsigned RUN   = 4,
  parameter int unsigned CNT_W = $clog2(RUN + 1)
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic [CH-1:0] en,
  input  logic          clr,
  input  logic [1:0]    mode,
  input  logic [CH-1:0] w,
  output logic [CH-1:0] q,
  output logic [CH-1:0] hit,
  output logic [CH-1:0] val
);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    run_detect_ch #(
      .RUN  (RUN),
      .CNT_W(CNT_W)
    ) u_ch (
      .clk  (clk),
      .Reset(Reset),
      .clr  (clr),
      .mode (mode),
      .en   (en[i]),
      .w    (w[i]),
      .q    (q[i]),
      .hit  (hit[i]),
      .val  (val[i])
    );
  end

endmodule

// File: tb/tb_run_detect.sv
// Randomised and directed check of run_detect against a run-length reference model.
module tb_run_detect;

  localparam int Run1 = 4;
  localparam int Run4 = 2;

  logic       clk = 1'b0;
  logic       Reset;
  logic       clr;
  logic [1:0] mode;
  logic       en1, w1;
  logic       q1, hit1, val1;
  logic [3:0] en4, w4;
  logic [3:0] q4, hit4, val4;

  int errs   = 0;
  int checks = 0;

  // Reference: length of the trailing run of equal accepted samples and its value.
  int rl1;
  bit last1, eq1, eh1;
  int rl4[4];
  bit last4[4], eq4[4], eh4[4];

  always #5 clk = ~clk;

  run_detect #(.CH(1), .RUN(Run1)) dut1 (
    .clk(clk), .Reset(Reset), .en(en1), .clr(clr), .mode(mode), .w(w1),
    .q(q1), .hit(hit1), .val(val1)
  );

  run_detect #(.CH(4), .RUN(Run4)) dut4 (
    .clk(clk), .Reset(Reset), .en(en4), .clr(clr), .mode(mode), .w(w4),
    .q(q4), .hit(hit4), .val(val4)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit allow_m(input bit v, input logic [1:0] m);
    return (m == 2'd0) || (m == 2'd1 && v) || (m == 2'd2 && !v);
  endfunction

  task automatic model_reset();
    rl1 = 0; last1 = 0; eq1 = 0; eh1 = 0;
    for (int i = 0; i < 4; i++) begin
      rl4[i] = 0; last4[i] = 0; eq4[i] = 0; eh4[i] = 0;
    end
  endtask

  task automatic model_edge();
    bit nq;
    if (Reset || clr) begin
      model_reset();
      return;
    end
    if (en1) begin
      if (rl1 == 0 || w1 != last1) begin rl1 = 1; last1 = w1; end
      else rl1++;
    end
    nq  = (rl1 >= Run1) && allow_m(last1, mode);
    eh1 = nq && !eq1;
    eq1 = nq;
    for (int i = 0; i < 4; i++) begin
      if (en4[i]) begin
        if (rl4[i] == 0 || w4[i] != last4[i]) begin rl4[i] = 1; last4[i] = w4[i]; end
        else rl4[i]++;
      end
      nq     = (rl4[i] >= Run4) && allow_m(last4[i], mode);
      eh4[i] = nq && !eq4[i];
      eq4[i] = nq;
    end
  endtask

  task automatic compare_all();
    check_eq("q1", 32'(q1), 32'(eq1));
    check_eq("hit1", 32'(hit1), 32'(eh1));
    check_eq("val1", 32'(val1), 32'(last1));
    check_eq("cnt1", 32'(dut1.g_ch[0].u_ch.cnt_q), 32'((rl1 > Run1) ? Run1 : rl1));
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("q4[%0d]", i), 32'(q4[i]), 32'(eq4[i]));
      check_eq($sformatf("hit4[%0d]", i), 32'(hit4[i]), 32'(eh4[i]));
      check_eq($sformatf("val4[%0d]", i), 32'(val4[i]), 32'(last4[i]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic feed1(input bit e, input bit v);
    en1 = e;
    w1  = v;
    tick();
  endtask

  task automatic rand4();
    en4 = 4'($urandom_range(0, 15));
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(0, 3) == 0) w4[i] = ~w4[i];
    end
  endtask

  initial begin
    bit seq[9];
    bit gaps[6];
    seq  = '{0, 0, 0, 0, 1, 1, 0, 1, 0};
    gaps = '{1, 0, 1, 0, 1, 1};
    Reset = 1'b1; clr = 1'b0; mode = 2'b00;
    en1 = 1'b0; w1 = 1'b0; en4 = 4'h0; w4 = 4'h0;
    model_reset();
    #1;
    check_eq("reset_q", 32'(q1), 32'd0);
    repeat (5) tick();
    Reset = 1'b0;

    // Basic mode 00 sequence.
    for (int k = 0; k < 9; k++) begin
      rand4();
      feed1(1'b1, seq[k]);
      if (k == 3) begin
        check_eq("seq_q_rise", 32'(q1), 32'd1);
        check_eq("seq_hit", 32'(hit1), 32'd1);
      end
      if (k == 4) check_eq("seq_q_fall", 32'(q1), 32'd0);
    end

    // Saturation on ones.
    mode = 2'b01;
    for (int k = 0; k < 10; k++) begin
      rand4();
      feed1(1'b1, 1'b1);
    end
    check_eq("sat_q", 32'(q1), 32'd1);
    check_eq("sat_cnt", 32'(dut1.g_ch[0].u_ch.cnt_q), 32'd4);

    // Enable gaps on a fresh run.
    feed1(1'b1, 1'b0);
    for (int k = 0; k < 6; k++) feed1(gaps[k], 1'b1);
    check_eq("gap_q", 32'(q1), 32'd1);

    // Mode switch on a held run of zeros.
    for (int k = 0; k < 4; k++) feed1(1'b1, 1'b0);
    check_eq("mode01_zero_q", 32'(q1), 32'd0);
    mode = 2'b10;
    feed1(1'b0, 1'b0);
    check_eq("mode10_q", 32'(q1), 32'd1);
    check_eq("mode10_hit", 32'(hit1), 32'd1);
    mode = 2'b11;
    feed1(1'b0, 1'b0);
    check_eq("mode11_q", 32'(q1), 32'd0);
    check_eq("mode11_cnt", 32'(dut1.g_ch[0].u_ch.cnt_q), 32'd4);

    // Asynchronous reset mid-run.
    mode = 2'b00;
    feed1(1'b1, 1'b1);
    for (int k = 0; k < 3; k++) feed1(1'b1, 1'b1);
    check_eq("pre_rst_q", 32'(q1), 32'd1);
    #3 Reset = 1'b1;
    #1;
    model_reset();
    check_eq("arst_q", 32'(q1), 32'd0);
    check_eq("arst_hit", 32'(hit1), 32'd0);
    check_eq("arst_val", 32'(val1), 32'd0);
    compare_all();
    tick();
    Reset = 1'b0;
    for (int k = 0; k < 3; k++) feed1(1'b1, 1'b1);
    check_eq("post_rst_q3", 32'(q1), 32'd0);
    feed1(1'b1, 1'b1);
    check_eq("post_rst_q4", 32'(q1), 32'd1);

    // Synchronous clear mid-run.
    clr = 1'b1;
    feed1(1'b1, 1'b1);
    check_eq("clr_q", 32'(q1), 32'd0);
    check_eq("clr_val", 32'(val1), 32'd0);
    clr = 1'b0;
    for (int k = 0; k < 3; k++) feed1(1'b1, 1'b1);
    check_eq("post_clr_q3", 32'(q1), 32'd0);
    feed1(1'b1, 1'b1);
    check_eq("post_clr_q4", 32'(q1), 32'd1);

    // Random soak over both instances.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      clr = ($urandom_range(0, 99) == 0);
      en1 = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) w1 = ~w1;
      rand4();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
